// File: rtl/speckle_chip_emulator_if.sv
// Strobe bus from the speckle sensor controller to the chip (or its emulator).
// The controller drives the bus through the master modport, and the chip side reads it
// through the slave modport.
interface speckle_chip_emulator_if;
   logic chip_col_clk;
   logic chip_col_rst;
   logic chip_col_data;
   logic chip_row_clk;
   logic chip_row_rst;
   logic chip_row_ena;
   logic chip_row_data;
   logic chip_key_wren;

   modport master (
      output chip_col_clk, chip_col_rst, chip_col_data,
      output chip_row_clk, chip_row_rst, chip_row_ena, chip_row_data,
      output chip_key_wren
   );

   modport slave (
      input chip_col_clk, chip_col_rst, chip_col_data,
      input chip_row_clk, chip_row_rst, chip_row_ena, chip_row_data,
      input chip_key_wren
   );
endinterface

// File: rtl/speckle_chip_emulator.sv
// Speckle sensor chip emulator: rebuilds the column/row one-hot select shift registers from the
// asynchronous strobe bus, keeps an optional per-pixel key memory and presents an emulated pixel
// level to the ADC path.
// Optional feature macro: CHIP_EMU_KEY_MEM_EN enables key memory, key writes, the key offset term
// and the key counter. Without it, key strobes are ignored and o_key_count stays 0.
module speckle_chip_emulator #(
   parameter int unsigned         COLS       = 24,
   parameter int unsigned         ROWS       = 24,
   parameter int unsigned         NB_DATA    = 12,
   parameter int unsigned         PIX_STEP   = 7,
   parameter logic [NB_DATA-1:0]  KEY_OFFSET = 'h800
) (
   input  logic                             clk,
   input  logic                             rst,
   speckle_chip_emulator_if.slave           chip_bus,
   output logic [COLS-1:0]                  o_col_sel,
   output logic [ROWS-1:0]                  o_row_sel,
   output logic [NB_DATA-1:0]               o_pixel_val,
   output logic                             o_pixel_valid,
   output logic                             o_sel_err,
   output logic [$clog2(COLS*ROWS+1)-1:0]   o_key_count
);

   localparam int unsigned NumPix = COLS * ROWS;
   localparam int unsigned IdxW   = $clog2(NumPix);
   localparam int unsigned CntW   = $clog2(NumPix + 1);
   localparam int unsigned ColW   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int unsigned RowW   = (ROWS > 1) ? $clog2(ROWS) : 1;

   // Bit map: 0 col_clk, 1 col_rst, 2 col_data, 3 row_clk, 4 row_rst, 5 row_ena, 6 row_data,
   // 7 key_wren
   logic [7:0] async_in;
   logic [7:0] sync1_q, sync2_q;
   logic [2:0] edge_q;            // {key_wren, row_clk, col_clk} delayed by one more stage

   assign async_in = {chip_bus.chip_key_wren, chip_bus.chip_row_data, chip_bus.chip_row_ena,
                      chip_bus.chip_row_rst, chip_bus.chip_row_clk, chip_bus.chip_col_data,
                      chip_bus.chip_col_rst, chip_bus.chip_col_clk};

   // Two-flop synchronizers plus a third stage on the strobes for rising-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
         edge_q  <= '0;
      end else begin
         sync1_q <= async_in;
         sync2_q <= sync1_q;
         edge_q  <= {sync2_q[7], sync2_q[3], sync2_q[0]};
      end
   end

   logic col_rise, row_rise, key_rise;
   logic col_rst_s, col_data_s, row_rst_s, row_ena_s, row_data_s;

   assign col_rise   = sync2_q[0] & ~edge_q[0];
   assign row_rise   = sync2_q[3] & ~edge_q[1];
   assign key_rise   = sync2_q[7] & ~edge_q[2];
   assign col_rst_s  = sync2_q[1];
   assign col_data_s = sync2_q[2];
   assign row_rst_s  = sync2_q[4];
   assign row_ena_s  = sync2_q[5];
   assign row_data_s = sync2_q[6];

   logic [COLS-1:0] col_sr_q, col_sr_d;
   logic [ROWS-1:0] row_sr_q, row_sr_d;

   // Shift-register next state; a clear level wins over a simultaneous shift edge
   always_comb begin
      col_sr_d = col_sr_q;
      row_sr_d = row_sr_q;
      if (col_rst_s) begin
         col_sr_d = '0;
      end else if (col_rise) begin
         col_sr_d = {col_sr_q[COLS-2:0], col_data_s};
      end
      if (row_rst_s) begin
         row_sr_d = '0;
      end else if (row_rise) begin
         row_sr_d = {row_sr_q[ROWS-2:0], row_data_s};
      end
   end

   // Column and row select shift registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_sr_q <= '0;
         row_sr_q <= '0;
      end else begin
         col_sr_q <= col_sr_d;
         row_sr_q <= row_sr_d;
      end
   end

   assign o_col_sel = col_sr_q;
   assign o_row_sel = row_sr_q;

   logic [ColW-1:0] col_idx;
   logic [RowW-1:0] row_idx;
   logic            col_oh, row_oh, both_oh;
   logic [IdxW-1:0] pix_idx;

   // Selection decode: position of the set bit on each axis, meaningful only when one-hot
   always_comb begin
      col_idx = '0;
      row_idx = '0;
      for (int i = 0; i < COLS; i++) begin
         if (col_sr_q[i]) col_idx = ColW'(i);
      end
      for (int j = 0; j < ROWS; j++) begin
         if (row_sr_q[j]) row_idx = RowW'(j);
      end
   end

   assign col_oh  = $onehot(col_sr_q);
   assign row_oh  = $onehot(row_sr_q);
   assign both_oh = col_oh & row_oh;
   assign pix_idx = IdxW'(row_idx) * IdxW'(COLS) + IdxW'(col_idx);

   logic key_bit;

`ifdef CHIP_EMU_KEY_MEM_EN
   logic [NumPix-1:0] key_q, key_d;
   logic [CntW-1:0]   cnt_q, cnt_d;

   // Key write addresses the pre-shift selection, so a same-cycle column shift does not move it
   always_comb begin
      key_d = key_q;
      cnt_d = cnt_q;
      if (key_rise && both_oh) begin
         if (col_data_s && !key_q[pix_idx]) begin
            cnt_d = cnt_q + CntW'(1);
         end else if (!col_data_s && key_q[pix_idx]) begin
            cnt_d = cnt_q - CntW'(1);
         end
         key_d[pix_idx] = col_data_s;
      end
   end

   // Key memory and population count; only the global reset clears them
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         key_q <= '0;
         cnt_q <= '0;
      end else begin
         key_q <= key_d;
         cnt_q <= cnt_d;
      end
   end

   assign key_bit     = key_q[pix_idx];
   assign o_key_count = cnt_q;
`else
   logic unused_key_rise;
   assign unused_key_rise = key_rise;
   assign key_bit         = 1'b0;
   assign o_key_count     = '0;
`endif

   logic [NB_DATA-1:0] pix_lvl;
   logic [NB_DATA-1:0] val_q, val_d;
   logic               valid_q, valid_d, err_q, err_d;

   // Pixel level wraps modulo 2^NB_DATA, including the key offset
   assign pix_lvl = NB_DATA'(32'(pix_idx) * PIX_STEP) + (key_bit ? KEY_OFFSET : '0);

   // Pixel output next state from the current selection and row drive enable
   always_comb begin
      val_d   = '0;
      valid_d = 1'b0;
      err_d   = 1'b0;
      if (row_ena_s) begin
         if (both_oh) begin
            val_d   = pix_lvl;
            valid_d = 1'b1;
         end else begin
            err_d   = 1'b1;
         end
      end
   end

   // Registered pixel outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         val_q   <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         val_q   <= val_d;
         valid_q <= valid_d;
         err_q   <= err_d;
      end
   end

   assign o_pixel_val   = val_q;
   assign o_pixel_valid = valid_q;
   assign o_sel_err     = err_q;

endmodule
